// File: rtl/daq_adc_reader.sv
// Parallel ADC readout engine: detects end-of-conversion on BUSY, strobes CS_N/RD_N
// for NUM_CHANNELS words and streams each word with its channel index over valid/ready.
module daq_adc_reader #(
  parameter int unsigned NUM_CHANNELS   = 8,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned CH_WIDTH       = 3,
  parameter int unsigned RD_LOW_CYCLES  = 3,
  parameter int unsigned RD_HIGH_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  busy_i,
  input  logic [DATA_WIDTH-1:0] adc_data_i,
  output logic                  adc_cs_n_o,
  output logic                  adc_rd_n_o,
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic [CH_WIDTH-1:0]   chan_o,
  output logic                  sample_valid_o,
  input  logic                  sample_ready_i,
  output logic                  frame_start_o,
  output logic                  frame_done_o,
  output logic                  overrun_o,
  input  logic                  overrun_clr_i
);

  localparam int unsigned T_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int unsigned TW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_LOW  = 3'd1,
    S_RD_HIGH = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [CH_WIDTH-1:0] word_q, word_d;
  logic                busy_s1_q, busy_s2_q, busy_dly_q;
  logic                cs_n_d, rd_n_d, frame_start_d, frame_done_d;
  logic                capture_c, slot_free_c, eoc_c;

  // BUSY synchroniser plus delay flop; loads 1 so reset looks like an idle-high BUSY
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_s1_q  <= 1'b1;
      busy_s2_q  <= 1'b1;
      busy_dly_q <= 1'b1;
    end else begin
      busy_s1_q  <= busy_i;
      busy_s2_q  <= busy_s1_q;
      busy_dly_q <= busy_s2_q;
    end
  end

  assign eoc_c       = ~busy_s2_q & busy_dly_q;
  assign slot_free_c = ~sample_valid_o | sample_ready_i;

  // Next-state and strobe logic
  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    word_d        = word_q;
    cs_n_d        = adc_cs_n_o;
    rd_n_d        = adc_rd_n_o;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    capture_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        rd_n_d = 1'b1;
        if (eoc_c && en_i) begin
          state_d       = S_RD_LOW;
          cs_n_d        = 1'b0;
          rd_n_d        = 1'b0;
          frame_start_d = 1'b1;
          word_d        = '0;
          tmr_d         = '0;
        end
      end
      S_RD_LOW: begin
        // An unaccepted sample (possible only from a previous frame) stretches the strobe
        if (tmr_q == TW'(RD_LOW_CYCLES - 1)) begin
          if (slot_free_c) begin
            capture_c = 1'b1;
            rd_n_d    = 1'b1;
            tmr_d     = '0;
            state_d   = S_RD_HIGH;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_RD_HIGH: begin
        if (tmr_q == TW'(RD_HIGH_CYCLES - 1)) begin
          tmr_d = '0;
          if (word_q == CH_WIDTH'(NUM_CHANNELS - 1)) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end else begin
            word_d = word_q + CH_WIDTH'(1);
            if (slot_free_c) begin
              state_d = S_RD_LOW;
              rd_n_d  = 1'b0;
            end else begin
              state_d = S_HOLD;
            end
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_HOLD: begin
        if (sample_ready_i) begin
          state_d = S_RD_LOW;
          rd_n_d  = 1'b0;
          tmr_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        rd_n_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        rd_n_d  = 1'b1;
      end
    endcase
  end

  // State, strobe, sample and overrun registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      tmr_q          <= '0;
      word_q         <= '0;
      adc_cs_n_o     <= 1'b1;
      adc_rd_n_o     <= 1'b1;
      frame_start_o  <= 1'b0;
      frame_done_o   <= 1'b0;
      sample_o       <= '0;
      chan_o         <= '0;
      sample_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      word_q         <= word_d;
      adc_cs_n_o     <= cs_n_d;
      adc_rd_n_o     <= rd_n_d;
      frame_start_o  <= frame_start_d;
      frame_done_o   <= frame_done_d;
      sample_valid_o <= capture_c | (sample_valid_o & ~sample_ready_i);
      if (capture_c) begin
        sample_o <= adc_data_i;
        chan_o   <= word_q;
      end
      if (eoc_c && (state_q != S_IDLE)) begin
        overrun_o <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_daq_adc_reader.sv
// Directed bench for daq_adc_reader: default instance plus a 2-channel, 1/1-cycle strobe instance.
module tb_daq_adc_reader;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        en_i, busy_i, sample_ready_i, overrun_clr_i;
  logic [15:0] adc_data;
  logic        adc_cs_n_o, adc_rd_n_o, sample_valid_o, frame_start_o, frame_done_o, overrun_o;
  logic [15:0] sample_o;
  logic [2:0]  chan_o;

  logic        busy2, ready2;
  logic [15:0] adc_data2;
  logic        cs_n2, rd_n2, valid2, fs2, fd2, ovr2;
  logic [15:0] sample2;
  logic [2:0]  chan2;

  int vectors = 0;
  int miscompares = 0;
  int cs_low, rd_low, rd_falls, fs_cnt, fd_cnt, viol, exp_ch;
  logic prev_rd;

  always #5 clk_i = ~clk_i;

  daq_adc_reader u_dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .busy_i(busy_i),
    .adc_data_i(adc_data), .adc_cs_n_o(adc_cs_n_o), .adc_rd_n_o(adc_rd_n_o),
    .sample_o(sample_o), .chan_o(chan_o), .sample_valid_o(sample_valid_o),
    .sample_ready_i(sample_ready_i), .frame_start_o(frame_start_o),
    .frame_done_o(frame_done_o), .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i)
  );

  daq_adc_reader #(
    .NUM_CHANNELS(2), .DATA_WIDTH(16), .CH_WIDTH(3), .RD_LOW_CYCLES(1), .RD_HIGH_CYCLES(1)
  ) u_dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(1'b1), .busy_i(busy2),
    .adc_data_i(adc_data2), .adc_cs_n_o(cs_n2), .adc_rd_n_o(rd_n2),
    .sample_o(sample2), .chan_o(chan2), .sample_valid_o(valid2),
    .sample_ready_i(ready2), .frame_start_o(fs2),
    .frame_done_o(fd2), .overrun_o(ovr2), .overrun_clr_i(1'b0)
  );

  // ADC models: each RD_N falling edge within a CS_N-low span presents the next word
  logic prev_rd_m = 1'b1, prev_rd_m2 = 1'b1;
  int   cnt_m = 0, cnt_m2 = 0;
  always begin
    @(posedge clk_i);
    #1;
    if (adc_cs_n_o) cnt_m = 0;
    else if (!adc_rd_n_o && prev_rd_m) begin
      adc_data = 16'(32'h1000 + cnt_m);
      cnt_m++;
    end
    prev_rd_m = adc_rd_n_o;
    if (cs_n2) cnt_m2 = 0;
    else if (!rd_n2 && prev_rd_m2) begin
      adc_data2 = 16'(32'h2000 + cnt_m2);
      cnt_m2++;
    end
    prev_rd_m2 = rd_n2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic clr_stats();
    cs_low = 0; rd_low = 0; rd_falls = 0; fs_cnt = 0; fd_cnt = 0; viol = 0; exp_ch = 0;
    prev_rd = 1'b1;
  endtask

  // Raise then drop BUSY; CS_N must fall on the third edge that sees it low
  task automatic start_frame();
    busy_i = 1'b1;
    tick(3);
    busy_i = 1'b0;
    tick(1);
    chk("cs_n_e1", 32'(adc_cs_n_o), 1);
    tick(1);
    chk("cs_n_e2", 32'(adc_cs_n_o), 1);
    tick(1);
    chk("cs_n_e3", 32'(adc_cs_n_o), 0);
    chk("rd_n_e3", 32'(adc_rd_n_o), 0);
    chk("frame_start", 32'(frame_start_o), 1);
    clr_stats();
    cs_low = 1; rd_low = 1; rd_falls = 1; prev_rd = 1'b0;
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (!adc_cs_n_o) cs_low++;
      if (!adc_rd_n_o) rd_low++;
      if (!adc_rd_n_o && prev_rd) rd_falls++;
      prev_rd = adc_rd_n_o;
      if (!adc_rd_n_o && adc_cs_n_o) viol++;
      if (frame_start_o) fs_cnt++;
      if (frame_done_o) fd_cnt++;
      if (sample_valid_o && sample_ready_i) begin
        chk("sample_chan", 32'(chan_o), 32'(exp_ch));
        chk("sample_data", 32'(sample_o), 32'(32'h1000 + exp_ch));
        exp_ch++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; en_i = 1'b1; busy_i = 1'b1; sample_ready_i = 1'b1; overrun_clr_i = 1'b0;
    busy2 = 1'b1; ready2 = 1'b1; adc_data = '0; adc_data2 = '0;
    clr_stats();
    tick(2);
    chk("rst_cs_n", 32'(adc_cs_n_o), 1);
    chk("rst_rd_n", 32'(adc_rd_n_o), 1);
    chk("rst_sample", 32'(sample_o), 0);
    chk("rst_chan", 32'(chan_o), 0);
    chk("rst_valid", 32'(sample_valid_o), 0);
    chk("rst_fs", 32'(frame_start_o), 0);
    chk("rst_fd", 32'(frame_done_o), 0);
    chk("rst_ovr", 32'(overrun_o), 0);
    reset_i = 1'b0;
    tick(3);

    // Single frame, ready tied high
    start_frame();
    collect(45);
    chk("t1_words", 32'(exp_ch), 8);
    chk("t1_cs_low", 32'(cs_low), 41);
    chk("t1_rd_low", 32'(rd_low), 24);
    chk("t1_rd_pulses", 32'(rd_falls), 8);
    chk("t1_frame_done", 32'(fd_cnt), 1);
    chk("t1_rd_outside_cs", 32'(viol), 0);
    chk("t1_cs_n_end", 32'(adc_cs_n_o), 1);

    // Backpressure after chan 2 is captured
    start_frame();
    collect(12);
    tick(1);
    chk("t2_valid_c2", 32'(sample_valid_o), 1);
    chk("t2_chan_c2", 32'(chan_o), 2);
    chk("t2_data_c2", 32'(sample_o), 32'h1002);
    sample_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t2_hold_valid", 32'(sample_valid_o), 1);
      chk("t2_hold_chan", 32'(chan_o), 2);
      chk("t2_hold_data", 32'(sample_o), 32'h1002);
      chk("t2_hold_rd_n", 32'(adc_rd_n_o), 1);
    end
    chk("t2_hold_cs_n", 32'(adc_cs_n_o), 0);
    sample_ready_i = 1'b1;
    exp_ch = 3;
    tick(1);
    chk("t2_resume_rd_n", 32'(adc_rd_n_o), 0);
    chk("t2_resume_valid", 32'(sample_valid_o), 0);
    prev_rd = 1'b0; fd_cnt = 0;
    collect(40);
    chk("t2_words", 32'(exp_ch), 8);
    chk("t2_frame_done", 32'(fd_cnt), 1);

    // Overrun: second BUSY fall while chan 4 is being read
    start_frame();
    collect(16);
    busy_i = 1'b1;
    collect(3);
    busy_i = 1'b0;
    collect(2);
    chk("t3_ovr_before", 32'(overrun_o), 0);
    collect(1);
    chk("t3_ovr_set", 32'(overrun_o), 1);
    collect(45);
    chk("t3_words", 32'(exp_ch), 8);
    chk("t3_frame_done", 32'(fd_cnt), 1);
    chk("t3_no_restart", 32'(fs_cnt), 0);
    chk("t3_cs_n_idle", 32'(adc_cs_n_o), 1);
    chk("t3_ovr_sticky", 32'(overrun_o), 1);
    overrun_clr_i = 1'b1;
    tick(1);
    overrun_clr_i = 1'b0;
    chk("t3_ovr_clr", 32'(overrun_o), 0);

    // Set and clear on the same edge: set wins
    start_frame();
    collect(5);
    busy_i = 1'b1;
    collect(3);
    busy_i = 1'b0;
    collect(2);
    chk("t3b_ovr_before", 32'(overrun_o), 0);
    overrun_clr_i = 1'b1;
    collect(1);
    overrun_clr_i = 1'b0;
    chk("t3b_set_wins", 32'(overrun_o), 1);
    collect(45);
    chk("t3b_words", 32'(exp_ch), 8);
    overrun_clr_i = 1'b1;
    tick(1);
    overrun_clr_i = 1'b0;
    chk("t3b_ovr_clr", 32'(overrun_o), 0);

    // Disabled: BUSY fall ignored, no overrun
    en_i = 1'b0;
    busy_i = 1'b1;
    tick(3);
    busy_i = 1'b0;
    clr_stats();
    collect(10);
    chk("t4_cs_low", 32'(cs_low), 0);
    chk("t4_no_start", 32'(fs_cnt), 0);
    chk("t4_no_samples", 32'(exp_ch), 0);
    chk("t4_no_ovr", 32'(overrun_o), 0);

    // en_i dropped mid-frame: frame still completes
    en_i = 1'b1;
    start_frame();
    collect(10);
    en_i = 1'b0;
    collect(45);
    chk("t4_words", 32'(exp_ch), 8);
    chk("t4_frame_done", 32'(fd_cnt), 1);
    en_i = 1'b1;

    // Asynchronous reset during RD_LOW of chan 5
    start_frame();
    collect(26);
    chk("t5_pre_rd_n", 32'(adc_rd_n_o), 0);
    chk("t5_pre_words", 32'(exp_ch), 5);
    #2;
    reset_i = 1'b1;
    busy_i = 1'b1;
    #1;
    chk("t5_cs_n", 32'(adc_cs_n_o), 1);
    chk("t5_rd_n", 32'(adc_rd_n_o), 1);
    chk("t5_valid", 32'(sample_valid_o), 0);
    chk("t5_chan", 32'(chan_o), 0);
    tick(1);
    reset_i = 1'b0;
    tick(2);
    start_frame();
    collect(45);
    chk("t5_fresh_words", 32'(exp_ch), 8);
    chk("t5_fresh_done", 32'(fd_cnt), 1);

    // Two channels, 1-cycle strobes
    busy2 = 1'b0;
    tick(3);
    chk("t6_cs_n_start", 32'(cs_n2), 0);
    chk("t6_rd_n_start", 32'(rd_n2), 0);
    chk("t6_fs", 32'(fs2), 1);
    tick(1);
    chk("t6_rd_n_c0", 32'(rd_n2), 1);
    chk("t6_valid_c0", 32'(valid2), 1);
    chk("t6_chan_c0", 32'(chan2), 0);
    chk("t6_data_c0", 32'(sample2), 32'h2000);
    tick(1);
    chk("t6_rd_n_w1", 32'(rd_n2), 0);
    chk("t6_valid_w1", 32'(valid2), 0);
    tick(1);
    chk("t6_valid_c1", 32'(valid2), 1);
    chk("t6_chan_c1", 32'(chan2), 1);
    chk("t6_data_c1", 32'(sample2), 32'h2001);
    tick(1);
    chk("t6_fd", 32'(fd2), 1);
    chk("t6_cs_n_done", 32'(cs_n2), 0);
    tick(1);
    chk("t6_cs_n_idle", 32'(cs_n2), 1);
    chk("t6_fd_end", 32'(fd2), 0);
    chk("t6_ovr", 32'(ovr2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/daq_adc_reader.md
Name: daq_adc_reader

Overview:
Readout engine for the parallel-interface ADC whose conversions are started by the DAQ trigger controller. It detects end-of-conversion (falling BUSY) and drives CS_N/RD_N strobes to read NUM_CHANNELS words. Each word is presented on a valid/ready sample stream tagged with its channel index, for the downstream FIFO/USB packetiser.

Parameters:
NUM_CHANNELS, 8, channels read per conversion frame (2..16)
DATA_WIDTH, 16, ADC parallel data width
CH_WIDTH, 3, width of channel index (>= clog2(NUM_CHANNELS))
RD_LOW_CYCLES, 3, clk_i cycles RD_N is held low per word (>= 1)
RD_HIGH_CYCLES, 2, clk_i cycles RD_N is held high between words (>= 1)

Ports:
clk_i  input  1  system clock
reset_i  input  1  reset
en_i  input  1  readout enable, sampled only in IDLE
busy_i  input  1  ADC BUSY, asynchronous to clk_i
adc_data_i  input  DATA_WIDTH  ADC parallel data bus
adc_cs_n_o  output  1  ADC chip select, active low
adc_rd_n_o  output  1  ADC read strobe, active low
sample_o  output  DATA_WIDTH  captured sample
chan_o  output  CH_WIDTH  channel index of sample_o (0-based)
sample_valid_o  output  1  sample_o/chan_o valid
sample_ready_i  input  1  downstream accepts sample
frame_start_o  output  1  1-cycle pulse when CS_N falls
frame_done_o  output  1  1-cycle pulse after last word of frame
overrun_o  output  1  sticky: end-of-conversion missed
overrun_clr_i  input  1  clears overrun_o

Behaviour:
- Reset reset_i, asynchronous, active-high; clock clk_i. All logic is clocked on the rising edge of clk_i.
- Reset values: adc_cs_n_o=1, adc_rd_n_o=1, sample_o=0, chan_o=0, sample_valid_o=0, frame_start_o=0, frame_done_o=0, overrun_o=0. The FSM returns to IDLE and the synchronisers load 1 (BUSY-high idle).
- Reset asserted mid-frame aborts the frame immediately. The pending sample is discarded.
- busy_i passes through a 2-flop synchroniser plus one delay flop. An end-of-conversion (EOC) event is sync=0 and delayed=1.
- EOC appears 3 edges after the first edge that samples busy_i low.
- FSM states:
  - IDLE: cs_n=1, rd_n=1. On EOC with en_i=1, go to RD_LOW. On that edge cs_n=0, rd_n=0, frame_start_o=1 for one cycle, and the word counter is cleared. EOC with en_i=0 is ignored and does not count as an overrun.
  - RD_LOW: rd_n=0 for exactly RD_LOW_CYCLES cycles. On the edge ending the phase:
    - sample_o is loaded from adc_data_i and chan_o from the word counter;
    - sample_valid_o is set to 1 and rd_n to 1;
    - the FSM goes to RD_HIGH.
  - RD_HIGH: rd_n=1 for RD_HIGH_CYCLES cycles. At the end of the phase:
    - If the word counter equals NUM_CHANNELS-1, go to DONE.
    - Otherwise increment the counter. If (!sample_valid_o || sample_ready_i), go to RD_LOW (rd_n=0); else go to HOLD.
  - HOLD: cs_n=0, rd_n=1. Leave for RD_LOW on the first edge where sample_ready_i=1.
  - DONE: cs_n=1 and frame_done_o=1 for one cycle, then IDLE. A pending sample may still be valid; it is held until accepted.
- The cs_n low span is contiguous from frame_start to DONE. rd_n never goes low while cs_n is high.
- Output handshake:
  - A transfer occurs on an edge with sample_valid_o=1 and sample_ready_i=1.
  - sample_valid_o is cleared on that edge unless a new capture occurs on the same edge, in which case it stays 1 with the new data.
  - sample_o/chan_o are stable while valid is high and not yet accepted.
  - No sample is ever overwritten unaccepted.
- Overrun: an EOC detected in any state other than IDLE sets overrun_o. That event is dropped and the current frame continues. overrun_clr_i clears overrun_o; if set and clear coincide, set wins.
- en_i deassertion mid-frame does not abort; the current frame completes.
- Word counter width is CH_WIDTH and never wraps within a frame.

Test Plan:
- Single frame, ready tied 1, defaults: busy_i pulses high then low. Expect cs_n low 3 edges after busy is sampled low, and 8 rd_n low pulses of 3 cycles separated by 2 high cycles. Expect samples 0x1000+ch with chan 0..7, frame_start then frame_done, cs_n low for 8*5+1 cycles.
- Backpressure: sample_ready_i=0 for 10 cycles after chan 2 is captured. Expect a HOLD stall with rd_n=1 and cs_n=0, chan 2 data held stable, no lost or duplicated channel, and resumption 1 edge after ready=1.
- Overrun: a second busy falling edge is issued while chan 4 is reading. Expect overrun_o=1, the frame completes with 8 samples, and no second frame starts. Pulse overrun_clr_i: expect 0. Set+clear on the same cycle: expect 1.
- Disabled: en_i=0 on busy fall. Expect cs_n to stay 1, no samples and no overrun. en_i dropped mid-frame: the frame completes.
- Async reset asserted during RD_LOW of chan 5: expect cs_n=1, rd_n=1, valid=0 immediately without a clock. The next busy fall starts a fresh frame at chan 0.
- Parameter sweep NUM_CHANNELS=2, RD_LOW_CYCLES=1, RD_HIGH_CYCLES=1: expect 2 words, 1-cycle strobes, frame_done after chan 1.
